// File: rtl/cft_counter_pkg.sv
// Shared definitions for the CFT counter family: terminal value calculation
// and the direction encoding used by the next-value logic.
package cft_counter_pkg;

  localparam logic DirUp   = 1'b0;
  localparam logic DirDown = 1'b1;

  // Returned 33 bits wide so a 32-bit full-range counter is representable.
  function automatic logic [32:0] calc_maxv(input int unsigned width,
                                            input int unsigned modulus);
    logic [32:0] full;
    full = (33'd1 << width) - 33'd1;
    return (modulus == 0) ? full : (33'(modulus) - 33'd1);
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next count value and wrap detection for one up/down step.
module counter_next_val
  import cft_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             down_i,
  input  logic             sat_i,
  input  logic [WIDTH-1:0] maxv_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             wrap_o
);

  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;
  logic           up_ovf;
  logic           dn_unf;

  // One guard bit catches both the full-range overflow and the borrow out of zero.
  assign inc_ext = {1'b0, cnt_i} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_ext = {1'b0, cnt_i} - {{WIDTH{1'b0}}, 1'b1};
  assign up_ovf  = inc_ext > {1'b0, maxv_i};
  assign dn_unf  = dec_ext[WIDTH];

  always_comb begin
    nxt_o  = cnt_i;
    wrap_o = 1'b0;
    if (down_i == DirDown) begin
      if (dn_unf) begin
        if (!sat_i) begin
          nxt_o  = maxv_i;
          wrap_o = 1'b1;
        end
      end else begin
        nxt_o = dec_ext[WIDTH-1:0];
      end
    end else begin
      if (up_ovf) begin
        if (!sat_i) begin
          nxt_o  = '0;
          wrap_o = 1'b1;
        end
      end else begin
        nxt_o = inc_ext[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Modulus up/down counter with load, cascade enables, terminal count,
// registered wrap pulse and a strobed holding register.
module counter_updown_mod
  import cft_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 0,
  parameter int unsigned RESETVAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             cet_i,
  input  logic             cep_i,
  input  logic             down_i,
  input  logic             sat_i,
  input  logic             rck_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             rco_o
);

  localparam logic [32:0]      MaxvExt  = calc_maxv(WIDTH, MODULUS);
  localparam logic [WIDTH-1:0] Maxv     = MaxvExt[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESETVAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic [WIDTH-1:0] nxt;
  logic             wrap;
  logic [WIDTH-1:0] d_clamped;

  counter_next_val #(
    .WIDTH(WIDTH)
  ) u_next_val (
    .cnt_i (cnt_q),
    .down_i(down_i),
    .sat_i (sat_i),
    .maxv_i(Maxv),
    .nxt_o (nxt),
    .wrap_o(wrap)
  );

  // Loaded values beyond the modulus would be unreachable states; clamp them.
  assign d_clamped = (d_i > Maxv) ? Maxv : d_i;

  always_comb begin
    cnt_d = cnt_q;
    rco_d = 1'b0;
    q_d   = rck_i ? cnt_q : q_q;
    if (load_i) begin
      cnt_d = d_clamped;
    end else if (cet_i && cep_i) begin
      cnt_d = nxt;
      rco_d = wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= ResetVal;
      q_q   <= '0;
      rco_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
      rco_q <= rco_d;
    end
  end

  assign tc_o  = cet_i & ((down_i == DirDown) ? (cnt_q == '0) : (cnt_q == Maxv));
  assign cnt_o = cnt_q;
  assign q_o   = q_q;
  assign rco_o = rco_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench for counter_updown_mod: directed scenarios plus a
// randomized run against a plain-arithmetic reference model.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: WIDTH=4, MODULUS=10, RESETVAL=0
  logic       a_reset, a_load, a_cet, a_cep, a_down, a_sat, a_rck;
  logic [3:0] a_d, a_cnt, a_q;
  logic       a_tc, a_rco;
  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .RESETVAL(0)) u_a (
    .clk(clk), .reset(a_reset), .load_i(a_load), .d_i(a_d), .cet_i(a_cet), .cep_i(a_cep),
    .down_i(a_down), .sat_i(a_sat), .rck_i(a_rck), .cnt_o(a_cnt), .q_o(a_q), .tc_o(a_tc),
    .rco_o(a_rco)
  );

  // Instance B: WIDTH=8, full range
  logic       b_reset, b_load, b_cet, b_cep, b_down, b_sat, b_rck;
  logic [7:0] b_d, b_cnt, b_q;
  logic       b_tc, b_rco;
  counter_updown_mod #(.WIDTH(8), .MODULUS(0), .RESETVAL(0)) u_b (
    .clk(clk), .reset(b_reset), .load_i(b_load), .d_i(b_d), .cet_i(b_cet), .cep_i(b_cep),
    .down_i(b_down), .sat_i(b_sat), .rck_i(b_rck), .cnt_o(b_cnt), .q_o(b_q), .tc_o(b_tc),
    .rco_o(b_rco)
  );

  // Cascade: two 4-bit full-range stages
  logic       c_reset, c_cet;
  logic       c_zero = 1'b0;
  logic       c_one  = 1'b1;
  logic [3:0] c_d = 4'd0;
  logic [3:0] lo_cnt, lo_q, hi_cnt, hi_q;
  logic       lo_tc, lo_rco, hi_tc, hi_rco;
  counter_updown_mod #(.WIDTH(4), .MODULUS(0), .RESETVAL(0)) u_lo (
    .clk(clk), .reset(c_reset), .load_i(c_zero), .d_i(c_d), .cet_i(c_cet), .cep_i(c_one),
    .down_i(c_zero), .sat_i(c_zero), .rck_i(c_zero), .cnt_o(lo_cnt), .q_o(lo_q),
    .tc_o(lo_tc), .rco_o(lo_rco)
  );
  counter_updown_mod #(.WIDTH(4), .MODULUS(0), .RESETVAL(0)) u_hi (
    .clk(clk), .reset(c_reset), .load_i(c_zero), .d_i(c_d), .cet_i(lo_tc), .cep_i(c_one),
    .down_i(c_zero), .sat_i(c_zero), .rck_i(c_zero), .cnt_o(hi_cnt), .q_o(hi_q),
    .tc_o(hi_tc), .rco_o(hi_rco)
  );

  // Instance E: WIDTH=4, MODULUS=10, RESETVAL=3
  logic       e_reset, e_load, e_cet, e_cep, e_down, e_sat, e_rck;
  logic [3:0] e_d, e_cnt, e_q;
  logic       e_tc, e_rco;
  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .RESETVAL(3)) u_e (
    .clk(clk), .reset(e_reset), .load_i(e_load), .d_i(e_d), .cet_i(e_cet), .cep_i(e_cep),
    .down_i(e_down), .sat_i(e_sat), .rck_i(e_rck), .cnt_o(e_cnt), .q_o(e_q), .tc_o(e_tc),
    .rco_o(e_rco)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1; a_load = 0; a_d = 0; a_cet = 1; a_cep = 1; a_down = 0; a_sat = 0; a_rck = 1;
    b_reset = 1; b_load = 0; b_d = 0; b_cet = 0; b_cep = 0; b_down = 0; b_sat = 0; b_rck = 0;
    c_reset = 1; c_cet = 0;
    e_reset = 1; e_load = 0; e_d = 0; e_cet = 0; e_cep = 0; e_down = 0; e_sat = 0; e_rck = 0;
    tick();
    tick();
    n_tests++;
    if (a_cnt !== 4'd0 || a_q !== 4'd0 || a_rco !== 1'b0 || a_tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: cnt=%0d q=%0d rco=%b tc=%b, expected 0 0 0 0",
               a_cnt, a_q, a_rco, a_tc);
    end
    n_tests++;
    if (e_cnt !== 4'd3 || e_q !== 4'd0 || e_rco !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_e: cnt=%0d q=%0d rco=%b, expected 3 0 0", e_cnt, e_q, e_rco);
    end
    a_rck = 0;
  endtask

  task automatic test_count_wrap();
    a_reset = 0; a_cet = 1; a_cep = 1; a_down = 0; a_sat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_tests++;
      if (a_cnt !== 4'(i % 10) || a_rco !== (i % 10 == 0) || a_tc !== (i % 10 == 9)) begin
        n_fail++;
        $display("FAIL count_wrap step %0d: cnt=%0d rco=%b tc=%b, expected %0d %b %b",
                 i, a_cnt, a_rco, a_tc, i % 10, i % 10 == 0, i % 10 == 9);
      end
    end
  endtask

  task automatic test_load();
    a_cet = 0; a_cep = 0; a_load = 1; a_d = 4'd12;
    tick();
    n_tests++;
    if (a_cnt !== 4'd9) begin
      n_fail++; $display("FAIL load_clamp: cnt=%0d expected 9", a_cnt);
    end
    a_d = 4'd3;
    tick();
    n_tests++;
    if (a_cnt !== 4'd3) begin
      n_fail++; $display("FAIL load_no_enable: cnt=%0d expected 3", a_cnt);
    end
    a_cet = 1; a_cep = 1; a_d = 4'd7;
    tick();
    n_tests++;
    if (a_cnt !== 4'd7) begin
      n_fail++; $display("FAIL load_beats_count: cnt=%0d expected 7", a_cnt);
    end
    a_d = 4'd9;
    tick();
    a_d = 4'd0;   // count would wrap 9->0 here, but load takes the edge
    tick();
    n_tests++;
    if (a_cnt !== 4'd0 || a_rco !== 1'b0) begin
      n_fail++; $display("FAIL load_at_max: cnt=%0d rco=%b expected 0 0", a_cnt, a_rco);
    end
    a_load = 0;
  endtask

  task automatic test_down_sat();
    b_reset = 0; b_load = 1; b_d = 8'd2; b_down = 1; b_sat = 1; b_cet = 1; b_cep = 1;
    tick();
    b_load = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (b_cnt !== ((i == 0) ? 8'd1 : 8'd0) || b_rco !== 1'b0 || b_tc !== (i != 0)) begin
        n_fail++;
        $display("FAIL down_sat step %0d: cnt=%0d rco=%b tc=%b", i, b_cnt, b_rco, b_tc);
      end
    end
    b_sat = 0;
    tick();
    n_tests++;
    if (b_cnt !== 8'd255 || b_rco !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap: cnt=%0d rco=%b expected 255 1", b_cnt, b_rco);
    end
    tick();
    n_tests++;
    if (b_cnt !== 8'd254 || b_rco !== 1'b0) begin
      n_fail++; $display("FAIL down_after_wrap: cnt=%0d rco=%b expected 254 0", b_cnt, b_rco);
    end
  endtask

  task automatic test_cascade();
    c_reset = 0; c_cet = 1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_tests++;
      if ({hi_cnt, lo_cnt} !== 8'(k)) begin
        n_fail++;
        $display("FAIL cascade k=%0d: got 0x%02h expected 0x%02h", k, {hi_cnt, lo_cnt}, k);
      end
    end
  endtask

  task automatic test_rck();
    a_load = 1; a_d = 4'd5; a_cet = 1; a_cep = 1; a_down = 0; a_sat = 0; a_rck = 0;
    tick();
    a_load = 0; a_rck = 1;
    tick();
    n_tests++;
    if (a_cnt !== 4'd6 || a_q !== 4'd5) begin
      n_fail++; $display("FAIL rck_lag: cnt=%0d q=%0d expected 6 5", a_cnt, a_q);
    end
    tick();
    a_rck = 0;
    tick();
    tick();
    n_tests++;
    if (a_cnt !== 4'd9 || a_q !== 4'd6) begin
      n_fail++; $display("FAIL rck_hold: cnt=%0d q=%0d expected 9 6", a_cnt, a_q);
    end
  endtask

  task automatic test_reset_wrap();
    e_reset = 0; e_load = 1; e_d = 4'd9; e_rck = 1;
    tick();
    n_tests++;
    if (e_cnt !== 4'd9 || e_q !== 4'd3) begin
      n_fail++; $display("FAIL rw_setup: cnt=%0d q=%0d expected 9 3", e_cnt, e_q);
    end
    e_load = 0; e_cet = 1; e_cep = 1; e_reset = 1;
    tick();
    n_tests++;
    if (e_cnt !== 4'd3 || e_rco !== 1'b0 || e_q !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_at_wrap: cnt=%0d rco=%b q=%0d expected 3 0 0", e_cnt, e_rco, e_q);
    end
    e_reset = 0; e_rck = 0; e_load = 1; e_d = 4'd9;
    tick();
    e_load = 0; e_cep = 0; e_cet = 1;
    #1;
    n_tests++;
    if (e_tc !== 1'b1) begin
      n_fail++; $display("FAIL tc_no_cep: tc=%b expected 1", e_tc);
    end
    tick();
    n_tests++;
    if (e_cnt !== 4'd9 || e_tc !== 1'b1 || e_rco !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_no_cep: cnt=%0d tc=%b rco=%b expected 9 1 0", e_cnt, e_tc, e_rco);
    end
  endtask

  // Reference model: modulo-10 counter state tracked as plain integers.
  task automatic test_random();
    int m_cnt, m_q, m_rco, nv, exp_tc;
    int maxv = 9;
    a_reset = 1; a_load = 0; a_cet = 0; a_cep = 0; a_rck = 0;
    tick();
    m_cnt = 0; m_q = 0; m_rco = 0;
    for (int i = 0; i < 400; i++) begin
      a_reset = ($urandom_range(0, 31) == 0);
      a_load  = ($urandom_range(0, 7) == 0);
      a_d     = 4'($urandom_range(0, 15));
      a_cet   = ($urandom_range(0, 3) != 0);
      a_cep   = ($urandom_range(0, 3) != 0);
      a_down  = 1'($urandom_range(0, 1));
      a_sat   = ($urandom_range(0, 3) == 0);
      a_rck   = 1'($urandom_range(0, 1));
      #1;
      exp_tc = a_cet && (a_down ? (m_cnt == 0) : (m_cnt == maxv));
      n_tests++;
      if (a_tc !== 1'(exp_tc)) begin
        n_fail++; $display("FAIL rand_tc i=%0d: tc=%b expected %0d", i, a_tc, exp_tc);
      end
      if (a_reset) begin
        m_cnt = 0; m_q = 0; m_rco = 0;
      end else begin
        if (a_rck) m_q = m_cnt;
        m_rco = 0;
        if (a_load) begin
          m_cnt = (int'(a_d) > maxv) ? maxv : int'(a_d);
        end else if (a_cet && a_cep) begin
          nv = a_down ? m_cnt - 1 : m_cnt + 1;
          if (nv < 0 || nv > maxv) begin
            if (a_sat) nv = m_cnt;
            else begin
              nv = (nv + maxv + 1) % (maxv + 1);
              m_rco = 1;
            end
          end
          m_cnt = nv;
        end
      end
      tick();
      n_tests++;
      if (a_cnt !== 4'(m_cnt) || a_q !== 4'(m_q) || a_rco !== 1'(m_rco)) begin
        n_fail++;
        $display("FAIL rand_state i=%0d: cnt=%0d q=%0d rco=%b expected %0d %0d %0d",
                 i, a_cnt, a_q, a_rco, m_cnt, m_q, m_rco);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_load();
    test_down_sat();
    test_cascade();
    test_rck();
    test_reset_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
